lzw_hash_ctrl: RTL and testbench

LZW_HASH_CTRL -- requirements
Module: lzw_hash_ctrl

---
 rtl/lzw_pkg.sv | 25 ++
 rtl/lzw_char_packer.sv | 32 +++
 rtl/lzw_hash_ctrl.sv | 142 ++++++++++++++
 tb/tb_lzw_hash_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzw_pkg.sv
// Shared types and constants for the LZW hash controller and its character packer.
package lzw_pkg;

   localparam int CODE_W     = 12;
   localparam int CHAR_W     = 8;
   localparam int MAX_CHARS  = 8;
   localparam int NUM_CHAR_W = 3;
   localparam int PACK_W     = CHAR_W * MAX_CHARS;
   localparam int COUNT_W    = NUM_CHAR_W + 1;
   localparam int CYC_W      = 10;

   typedef enum logic [2:0] {
      IDLE,
      PACK,
      LOAD,
      RUN,
      OUT
   } state_t;

   // Character count to the LFSR's "count minus one" encoding; an empty string reads as 0.
   function automatic logic [NUM_CHAR_W-1:0] num_char_of(input logic [COUNT_W-1:0] count);
      return (count == '0) ? '0 : NUM_CHAR_W'(count - COUNT_W'(1));
   endfunction

endpackage

// File: rtl/lzw_char_packer.sv
// Left-shifting byte packer: newest character in [7:0], older ones move up,
// unused upper bytes stay zero because the register starts cleared.
module lzw_char_packer
   import lzw_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               shift_en,
   input  logic [CHAR_W-1:0]  data,
   output logic [PACK_W-1:0]  pack,
   output logic [COUNT_W-1:0] count,
   output logic               full
);

   // NOTE: sequential state uses <= so every register updates from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pack  <= '0;
         count <= '0;
      end else if (clear) begin
         pack  <= '0;
         count <= '0;
      end else if (shift_en) begin
         pack  <= {pack[PACK_W-CHAR_W-1:0], data};
         count <= count + COUNT_W'(1);
      end
   end

   assign full = (count == COUNT_W'(MAX_CHARS));

endmodule

// File: rtl/lzw_hash_ctrl.sv
// Packs up to 8 characters, runs them through lfsr_64_bit and presents the hashed code.
// Optional RUN timeout enabled by defining LZW_HASH_CTRL_TIMEOUT_EN.
module lzw_hash_ctrl
   import lzw_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [CHAR_W-1:0]     s_data,
   input  logic                  s_last,
   output logic                  lfsr_cs,
   output logic                  lfsr_rst,
   output logic [PACK_W-1:0]     lfsr_data,
   output logic [NUM_CHAR_W-1:0] lfsr_num_char,
   input  logic [CODE_W-1:0]     lfsr_code,
   input  logic                  lfsr_done,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [CODE_W-1:0]     m_code,
   output logic [NUM_CHAR_W-1:0] m_nchar,
   output logic                  m_err
);

   state_t               state, state_next;
   logic [PACK_W-1:0]    pack;
   logic [COUNT_W-1:0]   count;
   logic                 full;
   logic                 accept;
   logic                 last_byte;
   logic                 pack_clear;
   logic                 capture_ok;
   logic                 capture_to;
   logic                 timeout_hit;

   lzw_char_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .clear    (pack_clear),
      .shift_en (accept),
      .data     (s_data),
      .pack     (pack),
      .count    (count),
      .full     (full)
   );

   // Gated by rst so the source never sees ready while the block is held in reset.
   assign s_ready   = !rst && (state == IDLE || state == PACK) && !full;
   assign accept    = s_valid && s_ready;
   assign last_byte = s_last || (count == COUNT_W'(MAX_CHARS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      pack_clear = 1'b0;
      capture_ok = 1'b0;
      capture_to = 1'b0;
      lfsr_cs    = 1'b0;
      lfsr_rst   = 1'b0;
      unique case (state)
         IDLE, PACK: begin
            if (accept) state_next = last_byte ? LOAD : PACK;
         end
         LOAD: begin
            lfsr_cs    = 1'b1;
            state_next = RUN;
         end
         RUN: begin
            lfsr_cs  = 1'b1;
            lfsr_rst = 1'b1;
            if (lfsr_done) begin
               capture_ok = 1'b1;
               state_next = OUT;
            end else if (timeout_hit) begin
               capture_to = 1'b1;
               state_next = OUT;
            end
         end
         OUT: begin
            if (m_ready) begin
               pack_clear = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_code  <= '0;
         m_nchar <= '0;
      end else if (capture_ok) begin
         m_code  <= lfsr_code;
         m_nchar <= num_char_of(count);
      end else if (capture_to) begin
         m_code  <= '0;
         m_nchar <= num_char_of(count);
      end
   end

`ifdef LZW_HASH_CTRL_TIMEOUT_EN
   localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

   logic [CYC_W-1:0] cyc_cnt;
   logic             err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                cyc_cnt <= '0;
      else if (state == RUN)  cyc_cnt <= cyc_cnt + CYC_W'(1);
      else                    cyc_cnt <= '0;
   end

   assign timeout_hit = (state == RUN) && (cyc_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             err_q <= 1'b0;
      else if (capture_ok) err_q <= 1'b0;
      else if (capture_to) err_q <= 1'b1;
   end

   assign m_err = err_q;
`else
   // Without the timeout the parameter has no effect; RUN waits for lfsr_done forever.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout_hit    = 1'b0;
   assign m_err          = 1'b0;
`endif

   assign lfsr_data     = pack;
   assign lfsr_num_char = num_char_of(count);
   assign m_valid       = (state == OUT);

endmodule

// File: tb/tb_lzw_hash_ctrl.sv
// Self-checking bench for lzw_hash_ctrl: phase-level reference model plus directed strings.
// Honours LZW_HASH_CTRL_TIMEOUT_EN for the timeout scenario.
module tb_lzw_hash_ctrl;

   localparam int TO = 16;
   localparam int PH_COLLECT = 0;
   localparam int PH_LOAD    = 1;
   localparam int PH_RUN     = 2;
   localparam int PH_OUT     = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  s_data = 8'h00;
   logic        s_last = 1'b0;
   logic        lfsr_cs;
   logic        lfsr_rst;
   logic [63:0] lfsr_data;
   logic [2:0]  lfsr_num_char;
   logic [11:0] lfsr_code;
   logic        lfsr_done;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [11:0] m_code;
   logic [2:0]  m_nchar;
   logic        m_err;

   int          checks = 0;
   int          errors = 0;

   int          stub_lat  = 0;
   logic [11:0] stub_code = 12'h000;
   logic        spurious  = 1'b0;

   lzw_hash_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .s_last        (s_last),
      .lfsr_cs       (lfsr_cs),
      .lfsr_rst      (lfsr_rst),
      .lfsr_data     (lfsr_data),
      .lfsr_num_char (lfsr_num_char),
      .lfsr_code     (lfsr_code),
      .lfsr_done     (lfsr_done),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_code        (m_code),
      .m_nchar       (m_nchar),
      .m_err         (m_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stand-in for lfsr_64_bit: raises done after stub_lat run cycles (0 = never).
   int run_cnt;
   initial begin
      lfsr_done = 1'b0;
      lfsr_code = 12'h000;
      run_cnt   = 0;
      forever begin
         @(posedge clk);
         #1;
         if (lfsr_cs && lfsr_rst) run_cnt++;
         else                     run_cnt = 0;
         if (run_cnt != 0) begin
            lfsr_done = (stub_lat != 0) && (run_cnt >= stub_lat);
            lfsr_code = lfsr_done ? stub_code : 12'h000;
         end else begin
            lfsr_done = spurious;
            lfsr_code = spurious ? 12'hFFF : 12'h000;
         end
      end
   end

   // Reference model: the string being collected, the phase it is in, and the expected result.
   int          ph = PH_COLLECT;
   logic [7:0]  q[$];
   int          run_n = 0;
   logic [11:0] e_code = 12'h000;
   logic [2:0]  e_nchar = 3'd0;
   logic        e_err = 1'b0;

   function automatic logic [63:0] packed_string();
      logic [63:0] d = 64'h0;
      foreach (q[i]) d = {d[55:0], q[i]};
      return d;
   endfunction

   always @(negedge clk) begin : model
      logic [2:0] e_nc;
      e_nc = (q.size() == 0) ? 3'd0 : 3'(q.size() - 1);
      if (rst) begin
         check("rst_s_ready", s_ready, 0);
         check("rst_lfsr_cs", lfsr_cs, 0);
         check("rst_lfsr_rst", lfsr_rst, 0);
         check("rst_lfsr_data", lfsr_data, 0);
         check("rst_lfsr_num_char", lfsr_num_char, 0);
         check("rst_m_valid", m_valid, 0);
         check("rst_m_code", m_code, 0);
         check("rst_m_nchar", m_nchar, 0);
         check("rst_m_err", m_err, 0);
         ph = PH_COLLECT;
         q.delete();
      end else begin
         check("s_ready", s_ready, ph == PH_COLLECT);
         check("lfsr_cs", lfsr_cs, ph == PH_LOAD || ph == PH_RUN);
         check("lfsr_rst", lfsr_rst, ph == PH_RUN);
         check("lfsr_data", lfsr_data, packed_string());
         check("lfsr_num_char", lfsr_num_char, e_nc);
         check("m_valid", m_valid, ph == PH_OUT);
         if (ph == PH_OUT) begin
            check("m_code", m_code, e_code);
            check("m_nchar", m_nchar, e_nchar);
            check("m_err", m_err, e_err);
         end
`ifndef LZW_HASH_CTRL_TIMEOUT_EN
         check("m_err_tied", m_err, 0);
`endif
         case (ph)
            PH_COLLECT: begin
               if (s_valid) begin
                  q.push_back(s_data);
                  if (s_last || q.size() == 8) ph = PH_LOAD;
               end
            end
            PH_LOAD: begin
               ph    = PH_RUN;
               run_n = 0;
            end
            PH_RUN: begin
               if (lfsr_done) begin
                  e_code  = lfsr_code;
                  e_nchar = e_nc;
                  e_err   = 1'b0;
                  ph      = PH_OUT;
               end else begin
                  run_n++;
`ifdef LZW_HASH_CTRL_TIMEOUT_EN
                  if (run_n == TO) begin
                     e_code  = 12'h000;
                     e_nchar = e_nc;
                     e_err   = 1'b1;
                     ph      = PH_OUT;
                  end
`endif
               end
            end
            default: begin
               if (m_ready) begin
                  ph = PH_COLLECT;
                  q.delete();
               end
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      logic ok = 1'b0;
      s_valid = 1'b1;
      s_data  = b;
      s_last  = last;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("byte_accepted", ok, 1);
   endtask

   task automatic wait_load(input logic [63:0] d, input logic [2:0] nc);
      logic found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (lfsr_cs && !lfsr_rst) begin
            found = 1'b1;
            break;
         end
      end
      check("load_seen", found, 1);
      check("load_data", lfsr_data, d);
      check("load_num_char", lfsr_num_char, nc);
      tick();
   endtask

   task automatic wait_result(input logic [11:0] code, input logic [2:0] nc, input logic err);
      logic found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            found = 1'b1;
            break;
         end
      end
      check("result_seen", found, 1);
      check("result_code", m_code, code);
      check("result_nchar", m_nchar, nc);
      check("result_err", m_err, err);
      tick();
   endtask

   logic [7:0] word [8];

   initial begin : driver
      logic found;
      int   seen;
      word = '{8'h62, 8'h61, 8'h6E, 8'h6A, 8'h6F, 8'h69, 8'h6E, 8'h67};

      rst = 1'b1;
      repeat (3) tick();
      check("rst_hold_s_ready", s_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_s_ready", s_ready, 1);
      tick();

      // Single character; a stray lfsr_done while idle must be ignored.
      spurious = 1'b1;
      repeat (3) tick();
      spurious  = 1'b0;
      stub_lat  = 5;
      stub_code = 12'h3A5;
      send_byte(8'hE3, 1'b1);
      wait_load(64'h0000_0000_0000_00E3, 3'd0);
      wait_result(12'h3A5, 3'd0, 1'b0);

      // Two characters.
      stub_lat  = 3;
      stub_code = 12'h1B7;
      send_byte(8'h2C, 1'b0);
      send_byte(8'hE3, 1'b1);
      wait_load(64'h0000_0000_0000_2CE3, 3'd1);
      wait_result(12'h1B7, 3'd1, 1'b0);

      // Eight characters without s_last, then a ninth byte that must wait.
      stub_lat  = 4;
      stub_code = 12'h0C4;
      for (int i = 0; i < 8; i++) send_byte(word[i], 1'b0);
      wait_load(64'h6261_6E6A_6F69_6E67, 3'd7);
      check("run_s_ready", s_ready, 0);
      send_byte(8'h78, 1'b1);
      wait_load(64'h0000_0000_0000_0078, 3'd0);
      wait_result(12'h0C4, 3'd0, 1'b0);

      // Downstream back-pressure for 10 cycles.
      m_ready   = 1'b0;
      stub_lat  = 2;
      stub_code = 12'h5A5;
      send_byte(8'h41, 1'b0);
      send_byte(8'h42, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_valid) begin
            found = 1'b1;
            break;
         end
      end
      check("stall_m_valid_seen", found, 1);
      repeat (10) begin
         @(negedge clk);
         check("stall_m_valid", m_valid, 1);
         check("stall_m_code", m_code, 12'h5A5);
         check("stall_s_ready", s_ready, 0);
      end
      tick();
      m_ready = 1'b1;
      wait_result(12'h5A5, 3'd1, 1'b0);

      // LFSR never completes.
      stub_lat = 0;
      send_byte(8'h55, 1'b1);
`ifdef LZW_HASH_CTRL_TIMEOUT_EN
      wait_result(12'h000, 3'd0, 1'b1);
`else
      seen = 0;
      repeat (100) begin
         @(negedge clk);
         if (m_valid) seen++;
      end
      check("no_timeout_m_valid", seen, 0);
      tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
`endif

      // Reset in the middle of RUN abandons the string.
      stub_lat = 0;
      send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b1);
      wait_load(64'h0000_0000_0000_1020, 3'd1);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("midrst_lfsr_cs", lfsr_cs, 0);
      check("midrst_lfsr_rst", lfsr_rst, 0);
      check("midrst_lfsr_data", lfsr_data, 0);
      check("midrst_s_ready", s_ready, 0);
      check("midrst_m_valid", m_valid, 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      stub_lat  = 2;
      stub_code = 12'h2B1;
      send_byte(8'h41, 1'b1);
      wait_load(64'h0000_0000_0000_0041, 3'd0);
      wait_result(12'h2B1, 3'd0, 1'b0);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog: time limit reached, got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
